// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, ALU op codes, forwarding selects.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SLL = 3'b001,
    ALU_SUB = 3'b010,
    ALU_SRA = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SRL = 3'b101,
    ALU_OR  = 3'b110,
    ALU_AND = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// Per-source result forwarding: EX/MEM beats MEM/WB beats the registered regfile value.
module fwd_mux #(
  parameter int unsigned XLEN = cpu_pkg::XLEN,
  parameter int unsigned RA_W = cpu_pkg::RA_W
) (
  input  logic [RA_W-1:0] src,
  input  logic [XLEN-1:0] reg_value,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_wen,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_wen,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] value
);
  import cpu_pkg::*;

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_REG;
    if (src != '0 && exmem_wen && exmem_rd == src)
      sel = FWD_EXMEM;
    else if (src != '0 && memwb_wen && memwb_rd == src)
      sel = FWD_MEMWB;
  end

  // x0 is hardwired to zero whatever the regfile read returned.
  always_comb begin
    value = '0;
    case (sel)
      FWD_EXMEM: value = exmem_result;
      FWD_MEMWB: value = memwb_result;
      default:   value = (src == '0) ? '0 : reg_value;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: forwarding, operand select, load-use bubbles.
module id_ex_operand_stage #(
  parameter int unsigned XLEN = cpu_pkg::XLEN,
  parameter int unsigned RA_W = cpu_pkg::RA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_alusel,
  input  logic            in_op1_pc,
  input  logic            in_op2_imm,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic            in_reg_wen,
  input  logic            in_mem_ren,
  input  logic            in_mem_wen,
  input  logic            stall,
  input  logic            flush,
  input  logic [RA_W-1:0] exmem_rd,
  input  logic            exmem_wen,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [RA_W-1:0] memwb_rd,
  input  logic            memwb_wen,
  input  logic [XLEN-1:0] memwb_result,
  output logic            load_use,
  output logic            ex_valid,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [2:0]      alusel,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_wen,
  output logic            ex_mem_ren,
  output logic            ex_mem_wen
);
  import cpu_pkg::*;

  logic [RA_W-1:0] rs1_addr_q, rs2_addr_q;
  logic [XLEN-1:0] rs1_data_q, rs2_data_q, imm_q;
  alu_op_e         alusel_q;
  logic            op1_pc_q, op2_imm_q;
  logic            reg_wen_q, mem_ren_q, mem_wen_q;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    load_use = ex_valid && mem_ren_q && (ex_rd != '0) && in_valid &&
               ((in_rs1_addr == ex_rd) ||
                (in_rs2_addr == ex_rd && !in_op2_imm) ||
                (in_rs2_addr == ex_rd && in_mem_wen));
  end

  // Flush and bubble only kill valid/control; data fields are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_pc      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alusel_q   <= ALU_ADD;
      op1_pc_q   <= 1'b0;
      op2_imm_q  <= 1'b0;
      ex_rd      <= '0;
      reg_wen_q  <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_wen_q  <= 1'b0;
    end else if (flush || (!stall && load_use)) begin
      ex_valid  <= 1'b0;
      reg_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
      mem_wen_q <= 1'b0;
    end else if (!stall) begin
      ex_valid   <= in_valid;
      ex_pc      <= in_pc;
      rs1_addr_q <= in_rs1_addr;
      rs2_addr_q <= in_rs2_addr;
      rs1_data_q <= in_rs1_data;
      rs2_data_q <= in_rs2_data;
      imm_q      <= in_imm;
      alusel_q   <= alu_op_e'(in_alusel);
      op1_pc_q   <= in_op1_pc;
      op2_imm_q  <= in_op2_imm;
      ex_rd      <= in_rd_addr;
      reg_wen_q  <= in_reg_wen && in_valid;
      mem_ren_q  <= in_mem_ren && in_valid;
      mem_wen_q  <= in_mem_wen && in_valid;
    end
  end

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .src          (rs1_addr_q),
    .reg_value    (rs1_data_q),
    .exmem_rd     (exmem_rd),
    .exmem_wen    (exmem_wen),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_wen    (memwb_wen),
    .memwb_result (memwb_result),
    .value        (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .src          (rs2_addr_q),
    .reg_value    (rs2_data_q),
    .exmem_rd     (exmem_rd),
    .exmem_wen    (exmem_wen),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_wen    (memwb_wen),
    .memwb_result (memwb_result),
    .value        (fwd_rs2)
  );

  always_comb begin
    operand1      = op1_pc_q  ? ex_pc : fwd_rs1;
    operand2      = op2_imm_q ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
    alusel        = alusel_q;
    ex_reg_wen    = reg_wen_q && ex_valid;
    ex_mem_ren    = mem_ren_q && ex_valid;
    ex_mem_wen    = mem_wen_q && ex_valid;
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage with hand-computed expectations.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [2:0]  in_alusel;
  logic        in_op1_pc, in_op2_imm, in_reg_wen, in_mem_ren, in_mem_wen;
  logic        stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_wen, memwb_wen;
  logic [31:0] exmem_result, memwb_result;
  logic        load_use, ex_valid;
  logic [31:0] operand1, operand2, ex_store_data, ex_pc;
  logic [2:0]  alusel;
  logic [4:0]  ex_rd;
  logic        ex_reg_wen, ex_mem_ren, ex_mem_wen;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alusel(in_alusel), .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm),
    .in_rd_addr(in_rd_addr), .in_reg_wen(in_reg_wen), .in_mem_ren(in_mem_ren),
    .in_mem_wen(in_mem_wen), .stall(stall), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_wen(exmem_wen), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_wen(memwb_wen), .memwb_result(memwb_result),
    .load_use(load_use), .ex_valid(ex_valid), .operand1(operand1),
    .operand2(operand2), .alusel(alusel), .ex_store_data(ex_store_data),
    .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    in_valid = 0; in_pc = '0; in_rs1_addr = '0; in_rs2_addr = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_alusel = 3'b000;
    in_op1_pc = 0; in_op2_imm = 0; in_rd_addr = '0;
    in_reg_wen = 0; in_mem_ren = 0; in_mem_wen = 0;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0;
    exmem_rd = '0; exmem_wen = 0; exmem_result = '0;
    memwb_rd = '0; memwb_wen = 0; memwb_result = '0;
    clear_id();
    step(); step();
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_op1", operand1, 32'd0);
    check("rst_op2", operand2, 32'd0);
    check("rst_alusel", {29'd0, alusel}, 32'd0);
    rst_n = 1;

    // Plain capture
    in_valid = 1; in_pc = 32'h100; in_rs1_addr = 5'd1; in_rs1_data = 32'd5;
    in_rs2_addr = 5'd2; in_rs2_data = 32'd9; in_imm = 32'd7; in_op2_imm = 1;
    in_alusel = 3'b000; in_rd_addr = 5'd5; in_reg_wen = 1;
    step();
    check("cap_op1", operand1, 32'd5);
    check("cap_op2", operand2, 32'd7);
    check("cap_alusel", {29'd0, alusel}, 32'd0);
    check("cap_valid", {31'd0, ex_valid}, 32'd1);
    check("cap_pc", ex_pc, 32'h100);
    check("cap_store", ex_store_data, 32'd9);
    check("cap_rwen", {31'd0, ex_reg_wen}, 32'd1);

    // Asynchronous reset between edges
    #2 rst_n = 0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_op1", operand1, 32'd0);
    check("arst_op2", operand2, 32'd0);
    check("arst_alusel", {29'd0, alusel}, 32'd0);
    @(negedge clk) rst_n = 1;

    // Forwarding priority
    clear_id();
    in_valid = 1; in_rs1_addr = 5'd3; in_rs1_data = 32'h11;
    in_rs2_addr = 5'd7; in_rs2_data = 32'h22; in_alusel = 3'b010;
    exmem_rd = 5'd3; exmem_wen = 1; exmem_result = 32'hAA;
    memwb_rd = 5'd3; memwb_wen = 1; memwb_result = 32'hBB;
    step();
    check("fwd_exmem", operand1, 32'hAA);
    check("fwd_rs2_reg", operand2, 32'h22);
    check("fwd_alusel", {29'd0, alusel}, 32'b010);
    exmem_wen = 0; #1;
    check("fwd_memwb", operand1, 32'hBB);
    memwb_wen = 0; #1;
    check("fwd_reg", operand1, 32'h11);
    in_rs1_addr = 5'd0; in_rs1_data = 32'd0;
    exmem_rd = 5'd0; exmem_wen = 1; memwb_rd = 5'd0; memwb_wen = 1;
    step();
    check("fwd_x0", operand1, 32'd0);
    in_op1_pc = 1; in_pc = 32'h200;
    step();
    check("op1_pc", operand1, 32'h200);
    exmem_wen = 0; memwb_wen = 0;

    // Load-use
    clear_id();
    in_valid = 1; in_rd_addr = 5'd4; in_mem_ren = 1; in_reg_wen = 1;
    step();
    check("ld_mem_ren", {31'd0, ex_mem_ren}, 32'd1);
    clear_id();
    in_valid = 1; in_rs1_addr = 5'd1; in_rs1_data = 32'h33;
    in_rs2_addr = 5'd4; in_rs2_data = 32'h44; in_op2_imm = 1;
    in_rd_addr = 5'd8; in_reg_wen = 1;
    #1;
    check("lu_imm_nouse", {31'd0, load_use}, 32'd0);
    in_mem_wen = 1; #1;
    check("lu_store_rs2", {31'd0, load_use}, 32'd1);
    in_mem_wen = 0; in_op2_imm = 0; #1;
    check("lu_rs2", {31'd0, load_use}, 32'd1);
    step();
    check("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    check("lu_bub_rwen", {31'd0, ex_reg_wen}, 32'd0);
    check("lu_bub_mren", {31'd0, ex_mem_ren}, 32'd0);
    check("lu_clear", {31'd0, load_use}, 32'd0);
    step();
    check("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_cap_rd", {27'd0, ex_rd}, 32'd8);
    check("lu_cap_op2", operand2, 32'h44);

    // Stall holds, flush beats stall
    clear_id();
    in_valid = 1; in_rs2_addr = 5'd9; in_rs2_data = 32'h99; in_rd_addr = 5'd12;
    stall = 1;
    step(); step();
    check("stall_op2", operand2, 32'h44);
    check("stall_rd", {27'd0, ex_rd}, 32'd8);
    check("stall_valid", {31'd0, ex_valid}, 32'd1);
    flush = 1;
    step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_rwen", {31'd0, ex_reg_wen}, 32'd0);
    stall = 0; flush = 0;

    // Store data forwarded regardless of op2_imm
    clear_id();
    in_valid = 1; in_op2_imm = 1; in_imm = 32'h55; in_rs2_addr = 5'd6;
    in_rs2_data = 32'h99; in_mem_wen = 1;
    memwb_rd = 5'd6; memwb_wen = 1; memwb_result = 32'h1234;
    step();
    check("st_op2", operand2, 32'h55);
    check("st_data", ex_store_data, 32'h1234);
    check("st_mwen", {31'd0, ex_mem_wen}, 32'd1);

    // Invalid slot captured: flags gated
    in_valid = 0; in_reg_wen = 1;
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_mwen", {31'd0, ex_mem_wen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
